pc_branch_unit: RTL

- Owns the program counter for the MIPS datapath and is the consumer of the ALU's result flags (zero, lt, gt).
- Each cycle it resolves branch and jump requests from decode against the ALU flags and registers the next PC.
- Supports a stall input for downstream hazards and keeps a saturating taken-redirect counter for debug.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/pc_target_gen.sv | 35 +++
 rtl/pc_branch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath encodings: branch types, PC-unit FSM states, reset PC.
package mips_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGT  = 3'd4;

    localparam logic ST_NORMAL = 1'b0;
    localparam logic ST_DELAY  = 1'b1;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // lt is "<=" from the ALU, so strict less-than needs !zero.
    function automatic logic br_cond(input logic [2:0] bt, input logic zero,
                                     input logic lt, input logic gt);
        case (bt)
            BR_BEQ:  br_cond = zero;
            BR_BNE:  br_cond = !zero;
            BR_BLT:  br_cond = lt && !zero;
            BR_BGT:  br_cond = gt;
            default: br_cond = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_target_gen.sv
// Combinational redirect resolution: condition check, target select by priority, alignment.
module pc_target_gen
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [2:0]  branch_type,
    input  logic [31:0] imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    input  logic        zero,
    input  logic        lt,
    input  logic        gt,
    output logic        redirect,
    output logic [31:0] target,
    output logic        misalign
);

    logic        br_taken;
    logic [31:0] raw;

    always_comb begin
        br_taken = br_cond(branch_type, zero, lt, gt);
        raw      = pc_plus4 + (imm << 2);
        if (jump_reg)
            raw = reg_target;
        else if (jump)
            raw = {pc_plus4[31:28], jump_target, 2'b00};
        redirect = jump_reg || jump || br_taken;
        misalign = redirect && (raw[1:0] != 2'b00);
        target   = {raw[31:2], 2'b00};
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter register, redirect commit, taken/addr_err flags and redirect counter.
// Optional delay slot behaviour is enabled with `define BRANCH_DELAY_SLOT_EN.
module pc_branch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       branch_type,
    input  logic [31:0]      imm,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    input  logic             jump_reg,
    input  logic [31:0]      reg_target,
    input  logic             zero,
    input  logic             lt,
    input  logic             gt,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             taken,
    output logic             addr_err,
    output logic [CNT_W-1:0] taken_cnt
);

    logic        redirect;
    logic        misalign;
    logic [31:0] target;

    assign pc_plus4 = pc + 32'd4;

    pc_target_gen u_tgen (
        .pc_plus4    (pc_plus4),
        .branch_type (branch_type),
        .imm         (imm),
        .jump        (jump),
        .jump_target (jump_target),
        .jump_reg    (jump_reg),
        .reg_target  (reg_target),
        .zero        (zero),
        .lt          (lt),
        .gt          (gt),
        .redirect    (redirect),
        .target      (target),
        .misalign    (misalign)
    );

    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = (taken_cnt == '1) ? taken_cnt : taken_cnt + CNT_W'(1);

`ifdef BRANCH_DELAY_SLOT_EN
    logic        state;
    logic [31:0] pend_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            taken       <= 1'b0;
            addr_err    <= 1'b0;
            taken_cnt   <= '0;
            state       <= ST_NORMAL;
            pend_target <= '0;
        end else if (stall) begin
            taken    <= 1'b0;
            addr_err <= 1'b0;
        end else if (state == ST_DELAY) begin
            // Requests in the delay slot are illegal and dropped.
            pc        <= pend_target;
            state     <= ST_NORMAL;
            taken     <= 1'b1;
            addr_err  <= 1'b0;
            taken_cnt <= cnt_inc;
        end else begin
            pc       <= pc_plus4;
            taken    <= 1'b0;
            addr_err <= redirect && misalign;
            if (redirect) begin
                pend_target <= target;
                state       <= ST_DELAY;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            taken     <= 1'b0;
            addr_err  <= 1'b0;
            taken_cnt <= '0;
        end else if (stall) begin
            taken    <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            pc       <= redirect ? target : pc_plus4;
            taken    <= redirect;
            addr_err <= misalign;
            if (redirect)
                taken_cnt <= cnt_inc;
        end
    end
`endif

endmodule
